// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder: behavioral CCI-P memory responder. Services 1-line reads
// and writes/fences from a line-addressed memory and returns in-order responses.
package ccip_mem_responder_pkg;
  localparam int CCIP_DATA_WIDTH = 512;

  localparam logic [1:0] VC_VA  = 2'd0;
  localparam logic [1:0] VC_VL0 = 2'd1;
  localparam logic [1:0] VC_VH0 = 2'd2;
  localparam logic [1:0] VC_VH1 = 2'd3;

  localparam logic [1:0] ASE_1CL = 2'b00;
  localparam logic [1:0] ASE_2CL = 2'b01;
  localparam logic [1:0] ASE_4CL = 2'b11;

  localparam logic [3:0] ASE_RDLINE_S = 4'h4;
  localparam logic [3:0] ASE_RDLINE_I = 4'h6;
  localparam logic [3:0] ASE_WRLINE_I = 4'h1;
  localparam logic [3:0] ASE_WRLINE_M = 4'h2;
  localparam logic [3:0] ASE_WRFENCE  = 4'h5;

  localparam logic [3:0] ASE_RD_RSP      = 4'h0;
  localparam logic [3:0] ASE_WR_RSP      = 4'h1;
  localparam logic [3:0] ASE_WRFENCE_RSP = 4'h4;

  typedef struct packed {
    logic [1:0]  vc;
    logic        sop;
    logic        rsvd0;
    logic [1:0]  len;
    logic [3:0]  reqtype;
    logic [5:0]  rsvd1;
    logic [41:0] addr;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd0;
    logic        hitmiss;
    logic [1:0]  rsvd1;
    logic [1:0]  clnum;
    logic [3:0]  resptype;
    logic [15:0] mdata;
  } RxHdr_t;
endpackage

module ccip_mem_responder
  import ccip_mem_responder_pkg::*;
#(
  parameter int MEM_AWIDTH     = 10,
  parameter int RD_LATENCY     = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALMFULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       SoftReset,
  input  TxHdr_t                     C0TxHdr,
  input  logic                       C0TxRdValid,
  input  TxHdr_t                     C1TxHdr,
  input  logic [CCIP_DATA_WIDTH-1:0] C1TxData,
  input  logic                       C1TxWrValid,
  output RxHdr_t                     C0RxHdr,
  output logic [CCIP_DATA_WIDTH-1:0] C0RxData,
  output logic                       C0RxRdValid,
  output RxHdr_t                     C1RxHdr,
  output logic                       C1RxWrValid,
  output logic                       C0TxAlmFull,
  output logic                       C1TxAlmFull,
  output logic [1:0]                 err_status
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_AF   = (PW+1)'(ALMFULL_THRESH);
  localparam logic [15:0] MIN_AGE  = 16'(RD_LATENCY - 1);

  typedef struct packed {
    logic [15:0]           mdata;
    logic [1:0]            vc;
    logic [MEM_AWIDTH-1:0] idx;
    logic [15:0]           ts;
  } rd_entry_t;

  typedef struct packed {
    logic [15:0] mdata;
    logic [1:0]  vc;
    logic        fence;
  } wr_entry_t;

  function automatic logic [1:0] map_vc(input logic [1:0] vc);
    return (vc == VC_VA) ? VC_VL0 : vc;
  endfunction

  logic [CCIP_DATA_WIDTH-1:0] mem [2**MEM_AWIDTH];
  logic [15:0]                cnt;

  rd_entry_t      rq_mem [FIFO_DEPTH];
  logic [PW-1:0]  rq_wptr, rq_rptr;
  logic [PW:0]    rq_count;
  rd_entry_t      rq_head, rq_new;
  logic           rq_empty, rq_full, rq_pop, rq_push;
  logic [15:0]    rq_age;
  logic           rd_len_ok, rd_len_err, rd_drop;

  wr_entry_t      wq_mem [FIFO_DEPTH];
  logic [PW-1:0]  wq_wptr, wq_rptr;
  logic [PW:0]    wq_count;
  wr_entry_t      wq_head, wq_new;
  logic           wq_empty, wq_full, wq_pop, wq_push;
  logic           wr_is_line, wr_is_fence, wr_ok, wr_len_err, wr_drop, mem_we;

  logic [MEM_AWIDTH-1:0]      wr_idx, rd_idx;
  logic [CCIP_DATA_WIDTH-1:0] rd_line;

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{C0TxHdr.sop, C0TxHdr.rsvd0, C0TxHdr.reqtype, C0TxHdr.rsvd1,
                             C0TxHdr.addr[41:MEM_AWIDTH], C1TxHdr.sop, C1TxHdr.rsvd0,
                             C1TxHdr.rsvd1, C1TxHdr.addr[41:MEM_AWIDTH]};

  // Request decode, queue push/pop decisions and read-data forwarding
  always_comb begin
    rq_head  = rq_mem[rq_rptr];
    wq_head  = wq_mem[wq_rptr];
    rq_empty = (rq_count == '0);
    rq_full  = (rq_count == CNT_FULL);
    wq_empty = (wq_count == '0);
    wq_full  = (wq_count == CNT_FULL);

    rq_age   = cnt - rq_head.ts;
    rq_pop   = !rq_empty && (rq_age >= MIN_AGE);

    rd_len_ok  = C0TxRdValid && (C0TxHdr.len == ASE_1CL);
    rd_len_err = C0TxRdValid && (C0TxHdr.len != ASE_1CL);
    rq_push    = rd_len_ok && (!rq_full || rq_pop);
    rd_drop    = rd_len_ok && !rq_push;

    wr_is_line  = (C1TxHdr.reqtype == ASE_WRLINE_I) || (C1TxHdr.reqtype == ASE_WRLINE_M);
    wr_is_fence = (C1TxHdr.reqtype == ASE_WRFENCE);
    wr_ok       = C1TxWrValid && (wr_is_fence || (wr_is_line && C1TxHdr.len == ASE_1CL));
    wr_len_err  = C1TxWrValid && wr_is_line && (C1TxHdr.len != ASE_1CL);
    wq_pop      = !wq_empty;
    wq_push     = wr_ok && (!wq_full || wq_pop);
    wr_drop     = wr_ok && !wq_push;
    mem_we      = wq_push && wr_is_line;

    rq_new = '{mdata: C0TxHdr.mdata, vc: C0TxHdr.vc,
               idx: C0TxHdr.addr[MEM_AWIDTH-1:0], ts: cnt};
    wq_new = '{mdata: C1TxHdr.mdata, vc: C1TxHdr.vc, fence: wr_is_fence};

    wr_idx = C1TxHdr.addr[MEM_AWIDTH-1:0];
    rd_idx = rq_head.idx;
    // A write landing in the issue cycle is forwarded so the read sees it
    rd_line = (mem_we && wr_idx == rd_idx) ? C1TxData : mem[rd_idx];
  end

  // Line memory and queue storage; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we)  mem[wr_idx]     <= C1TxData;
    if (rq_push) rq_mem[rq_wptr] <= rq_new;
    if (wq_push) wq_mem[wq_wptr] <= wq_new;
  end

  // Cycle counter, queue pointers/occupancy and sticky error flags
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      cnt        <= '0;
      rq_wptr    <= '0;
      rq_rptr    <= '0;
      rq_count   <= '0;
      wq_wptr    <= '0;
      wq_rptr    <= '0;
      wq_count   <= '0;
      err_status <= '0;
    end else begin
      cnt <= cnt + 16'd1;
      if (rq_push) rq_wptr <= rq_wptr + 1'b1;
      if (rq_pop)  rq_rptr <= rq_rptr + 1'b1;
      if (wq_push) wq_wptr <= wq_wptr + 1'b1;
      if (wq_pop)  wq_rptr <= wq_rptr + 1'b1;
      case ({rq_push, rq_pop})
        2'b10:   rq_count <= rq_count + 1'b1;
        2'b01:   rq_count <= rq_count - 1'b1;
        default: rq_count <= rq_count;
      endcase
      case ({wq_push, wq_pop})
        2'b10:   wq_count <= wq_count + 1'b1;
        2'b01:   wq_count <= wq_count - 1'b1;
        default: wq_count <= wq_count;
      endcase
      err_status[0] <= err_status[0] | rd_len_err | wr_len_err;
      err_status[1] <= err_status[1] | rd_drop | wr_drop;
    end
  end

  // Registered response channels driven from the queue heads
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      C0RxHdr     <= '0;
      C0RxData    <= '0;
      C0RxRdValid <= 1'b0;
      C1RxHdr     <= '0;
      C1RxWrValid <= 1'b0;
    end else begin
      C0RxRdValid <= rq_pop;
      if (rq_pop) begin
        C0RxHdr          <= '0;
        C0RxHdr.vc_used  <= map_vc(rq_head.vc);
        C0RxHdr.clnum    <= ASE_1CL;
        C0RxHdr.resptype <= ASE_RD_RSP;
        C0RxHdr.mdata    <= rq_head.mdata;
        C0RxData         <= rd_line;
      end
      C1RxWrValid <= wq_pop;
      if (wq_pop) begin
        C1RxHdr          <= '0;
        C1RxHdr.vc_used  <= map_vc(wq_head.vc);
        C1RxHdr.clnum    <= ASE_1CL;
        C1RxHdr.resptype <= wq_head.fence ? ASE_WRFENCE_RSP : ASE_WR_RSP;
        C1RxHdr.mdata    <= wq_head.mdata;
      end
    end
  end

  assign C0TxAlmFull = (rq_count >= CNT_AF);
  assign C1TxAlmFull = (wq_count >= CNT_AF);

endmodule
